// File: rtl/eight_bit_shift_register.sv
// eight_bit_shift_register
//   Serial-in, parallel-out shift register. One bit is captured on every
//   rising clock edge and the last WIDTH captured bits are presented as a
//   parallel word. The newest bit sits at bit 0 and the oldest at the MSB.
//   The reset is asynchronous and active-low: it clears all history at
//   once, and its release is sampled on the next rising edge.

module eight_bit_shift_register #(
    parameter int unsigned WIDTH = 8   // register length, must be >= 2
) (
    input  logic             clk,
    input  logic             reset,    // active-low, asynchronous clear
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shift_q;

    // History register: clear on reset, otherwise shift the new bit in at the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= {shift_q[WIDTH-2:0], data_in};
        end
    end

    assign data_out = shift_q;

endmodule

// File: tb/tb_eight_bit_shift_register.sv
// tb_eight_bit_shift_register
//   Directed bench for the serial-in/parallel-out shift register. It uses a
//   table of per-edge vectors {reset, data_in, expected data_out}, followed by
//   hand-written sequences that exercise the asynchronous reset between clock
//   edges and confirm that data_in has no combinational path to data_out.

module tb_eight_bit_shift_register;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             data_in;
    logic [WIDTH-1:0] data_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic             rst;
        logic             din;
        logic [WIDTH-1:0] exp;
        string            name;
    } vec_t;

    vec_t vecs[$];

    eight_bit_shift_register #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Free-running clock with a 10-unit period. Rising edges occur at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog that guarantees the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic din,
                                input logic [WIDTH-1:0] exp, input string name);
        vec_t v;
        v.rst  = rst;
        v.din  = din;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    // Drive the inputs on the falling edge, then sample the output 1 unit
    // after the following rising edge.
    task automatic step(input logic rst, input logic din);
        @(negedge clk);
        reset   = rst;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Held in reset: zero.
        add(1'b0, 1'b0, 8'h00, "reset_hold");
        // Serial load 1,0,1,1,0,0,1,0 gives B2.
        add(1'b1, 1'b1, 8'h01, "load0");
        add(1'b1, 1'b0, 8'h02, "load1");
        add(1'b1, 1'b1, 8'h05, "load2");
        add(1'b1, 1'b1, 8'h0B, "load3");
        add(1'b1, 1'b0, 8'h16, "load4");
        add(1'b1, 1'b0, 8'h2C, "load5");
        add(1'b1, 1'b1, 8'h59, "load6");
        add(1'b1, 1'b0, 8'hB2, "load7");
        // Overflow: the oldest '1' falls off the MSB.
        add(1'b1, 1'b1, 8'h65, "overflow");
        // Mid-stream reset pulse, then shift 0,0,1.
        add(1'b0, 1'b1, 8'h00, "mid_reset");
        add(1'b1, 1'b0, 8'h00, "restart0");
        add(1'b1, 1'b0, 8'h00, "restart1");
        add(1'b1, 1'b1, 8'h01, "restart2");
        // Walking one, starting from zero.
        add(1'b0, 1'b0, 8'h00, "walk_reset");
        add(1'b1, 1'b1, 8'h01, "walk0");
        add(1'b1, 1'b0, 8'h02, "walk1");
        add(1'b1, 1'b0, 8'h04, "walk2");
        add(1'b1, 1'b0, 8'h08, "walk3");
        add(1'b1, 1'b0, 8'h10, "walk4");
        add(1'b1, 1'b0, 8'h20, "walk5");
        add(1'b1, 1'b0, 8'h40, "walk6");
        add(1'b1, 1'b0, 8'h80, "walk7");
        add(1'b1, 1'b0, 8'h00, "walk_out");
        // All-ones fill, then reset held low with data_in=1.
        add(1'b1, 1'b1, 8'h01, "ones0");
        add(1'b1, 1'b1, 8'h03, "ones1");
        add(1'b1, 1'b1, 8'h07, "ones2");
        add(1'b1, 1'b1, 8'h0F, "ones3");
        add(1'b1, 1'b1, 8'h1F, "ones4");
        add(1'b1, 1'b1, 8'h3F, "ones5");
        add(1'b1, 1'b1, 8'h7F, "ones6");
        add(1'b1, 1'b1, 8'hFF, "ones7");
        add(1'b0, 1'b1, 8'h00, "ones_reset0");
        add(1'b0, 1'b1, 8'h00, "ones_reset1");

        // Reset is asserted at time 0 and must clear the output before any clock edge.
        reset   = 1'b0;
        data_in = 1'b0;
        #2;
        check("async_reset_at_start", data_out, 8'h00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].din);
            check(vecs[i].name, data_out, vecs[i].exp);
        end

        // Refill to FF, then drop reset while clk is high and away from any edge.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        check("refill_ff", data_out, 8'hFF);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_between_edges", data_out, 8'h00);
        if (clk !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL async_timing: got clk=%b expected clk=1", clk);
        end

        // Toggling clk and data_in while reset is held low must leave the output at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = ~data_in;
            @(posedge clk);
            #1;
            check("reset_low_hold", data_out, 8'h00);
        end

        // Release reset: the first rising edge performs a normal shift.
        step(1'b1, 1'b1);
        check("release_first_shift", data_out, 8'h01);
        step(1'b1, 1'b0);
        check("release_second_shift", data_out, 8'h02);

        // A change on data_in between edges must not reach data_out.
        data_in = 1'b1;
        #2;
        check("no_comb_path", data_out, 8'h02);
        @(posedge clk);
        #1;
        check("sampled_after_edge", data_out, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
